// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing check.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err output.
module uart_rx #(
    parameter int BAUD_END  = 5208,
    parameter int BAUD_MID  = BAUD_END / 2 - 1,
    parameter int DATA_BITS = 8
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_flag,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_n;
    logic rx_r1, rx_r2, rx_r3;
    logic [2:0] settled;
    logic [12:0] baud_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic fall, strobe, last_bit, stop_ok, stop_bad;
    // settled[2] means rx_r3 holds a real line sample, so a line held low
    // through reset cannot masquerade as a start edge
    assign fall = settled[2] & rx_r3 & ~rx_r2;
    assign strobe = baud_cnt == 13'(BAUD_MID);
    assign last_bit = bit_cnt == 4'(DATA_BITS - 1);
    assign stop_ok = state == STOP && strobe && rx_r2;
    assign stop_bad = state == STOP && strobe && !rx_r2;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      state_n = fall ? START : IDLE;
            START:     state_n = strobe ? (rx_r2 ? IDLE : DATA) : START;
            DATA:      state_n = strobe && last_bit ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:    state_n = strobe ? STOP : PARITY;
`endif
            STOP:      state_n = strobe ? (rx_r2 ? IDLE : WAIT_HIGH) : STOP;
            WAIT_HIGH: state_n = rx_r2 ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state <= IDLE;
            {rx_r1, rx_r2, rx_r3} <= 3'b111;
            settled <= '0;
            baud_cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            rx_data <= '0;
            rx_flag <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_n;
            {rx_r1, rx_r2, rx_r3} <= {rs232_rx, rx_r1, rx_r2};
            settled <= {settled[1:0], 1'b1};
            baud_cnt <= (state == IDLE || baud_cnt == 13'(BAUD_END - 1)) ? '0 : baud_cnt + 13'd1;
            if (state == START)
                bit_cnt <= '0;
            else if (state == DATA && strobe)
                bit_cnt <= bit_cnt + 4'd1;
            if (state == DATA && strobe)
                shreg <= {rx_r2, shreg[7:1]};
            if (stop_ok)
                rx_data <= shreg;
            rx_flag <= stop_ok;
            frame_err <= stop_bad;
        end
    end
`ifdef UART_RX_PARITY_EN
    logic par_bit;
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            par_bit <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == PARITY && strobe)
                par_bit <= rx_r2;
            parity_err <= stop_ok & (^shreg ^ par_bit);
        end
    end
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    localparam int BE = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif
    typedef struct {
        logic       fe;
        logic       pe;
        logic [7:0] d;
        int         cyc;
    } exp_t;
    logic sclk = 1'b0, s_rst = 1'b1, rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic rx_flag, frame_err, busy, perr;
    int checks = 0, errors = 0, cyc = 0;
    exp_t sb[$];
    logic [7:0] last_good = 8'h00;
    logic prev_pulse = 1'b0;
    uart_rx #(.BAUD_END(BE)) dut (
        .sclk(sclk),
        .s_rst(s_rst),
        .rs232_rx(rs232_rx),
        .rx_data(rx_data),
        .rx_flag(rx_flag),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(perr),
`endif
        .busy(busy)
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif
    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b, input logic stop, input logic par, input logic pe);
        exp_t e;
        e.fe = ~stop;
        e.pe = pe;
        e.d = b;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        rs232_rx = 1'b0;
        repeat (BE) @(negedge sclk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (BE) @(negedge sclk);
        end
`ifdef UART_RX_PARITY_EN
        rs232_rx = par;
        repeat (BE) @(negedge sclk);
`else
        if (par !== ^b)
            $display("note: parity argument ignored in 8N1 build");
`endif
        rs232_rx = stop;
        repeat (BE) @(negedge sclk);
    endtask
    always @(negedge sclk) begin
        exp_t e;
        if (s_rst) begin
            last_good = 8'h00;
        end else if (rx_flag || frame_err) begin
            check("flag_and_err_exclusive", int'(rx_flag & frame_err), 0);
            check("pulse_width", int'(prev_pulse), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {rx_flag, frame_err}, 0);
            end else begin
                e = sb.pop_front();
                check("kind_frame_err", int'(frame_err), int'(e.fe));
                check("latency", cyc, e.cyc);
                if (rx_flag) begin
                    check("rx_data", rx_data, e.d);
                    check("parity_err", int'(perr), int'(e.pe));
                    last_good = e.d;
                end else begin
                    check("rx_data_hold", rx_data, last_good);
                end
            end
        end else if (perr) begin
            check("parity_err_alone", int'(perr), 0);
        end
        prev_pulse = rx_flag | frame_err;
    end
    initial begin
        logic [7:0] b;
        repeat (3) @(negedge sclk);
        check("reset_rx_data", rx_data, 0);
        check("reset_flags", {rx_flag, frame_err, perr, busy}, 0);
        s_rst = 1'b0;
        repeat (5) @(negedge sclk);
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (BE) @(negedge sclk);
        check("busy_after_a5", int'(busy), 0);
        send(8'h00, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        send(8'h55, 1'b1, 1'b0, 1'b0);
        repeat (BE) @(negedge sclk);
        rs232_rx = 1'b0;
        repeat (4) @(negedge sclk);
        check("glitch_busy_high", int'(busy), 1);
        rs232_rx = 1'b1;
        repeat (BE / 2 - 1 + 4) @(negedge sclk);
        check("glitch_back_idle", int'(busy), 0);
        repeat (BE) @(negedge sclk);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        rs232_rx = 1'b0;
        repeat (40) @(negedge sclk);
        check("wait_high_busy", int'(busy), 1);
        rs232_rx = 1'b1;
        repeat (20) @(negedge sclk);
        check("wait_high_released", int'(busy), 0);
        send(8'h81, 1'b1, 1'b0, 1'b0);
        repeat (BE) @(negedge sclk);
        b = 8'hC3;
        rs232_rx = 1'b0;
        repeat (BE) @(negedge sclk);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = b[i];
            repeat (BE) @(negedge sclk);
        end
        rs232_rx = b[4];
        repeat (BE / 2) @(negedge sclk);
        check("busy_mid_frame", int'(busy), 1);
        s_rst = 1'b1;
        @(negedge sclk);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_flags", {rx_flag, frame_err, perr, busy}, 0);
        s_rst = 1'b0;
        repeat (BE / 2) @(negedge sclk);
        check("low_after_reset_no_start", int'(busy), 0);
        for (int i = 5; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (BE) @(negedge sclk);
        end
        rs232_rx = 1'b1;
        repeat (2 * BE) @(negedge sclk);
        check("tail_discarded", int'(busy), 0);
        send(8'h7E, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
        repeat (BE) @(negedge sclk);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 300 && sb.size() != 0; i++)
            @(negedge sclk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_rx_data", rx_data, 8'h07 == 8'h07 && LAT == 171 ? 8'h07 : 8'h7E);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that decodes 8N1 serial frames from the rs232_rx pin into bytes. It is the upstream neighbour of the UART transmitter: its rx_data/rx_flag pair feeds the loopback/command path, which hands bytes to the TX stage. Default timing is 50 MHz sclk at 9600 baud. Sampling is at mid-bit, with start-bit glitch rejection and stop-bit framing check.

Parameters:
BAUD_END, 5208, sclk cycles per bit (50 MHz / 9600).
BAUD_MID, BAUD_END/2-1, baud_cnt value at which a bit is sampled.
DATA_BITS, 8, data bits per frame, sent LSB first; fixed at 8 for this revision.

Ports:
sclk  input  1  system clock; all logic on posedge.
s_rst  input  1  synchronous active-high reset.
rs232_rx  input  1  asynchronous serial line; idles high.
rx_data  output  8  last correctly framed byte; holds until the next good frame.
rx_flag  output  1  one-cycle pulse when rx_data updates.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
busy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is sclk, reset port is s_rst.
- Reset: rx_data=8'h00, rx_flag=0, frame_err=0, busy=0, state=IDLE, baud_cnt=0, bit_cnt=0, synchroniser flops=1.
- Input conditioning: 3-flop synchroniser rx_r1->rx_r2->rx_r3. A falling edge is detected when rx_r3=1 and rx_r2=0. All decisions use rx_r2.
- baud_cnt (13 bit): counts 0..BAUD_END-1 and wraps while state!=IDLE; forced to 0 in IDLE. Width must hold BAUD_END-1.
- bit_cnt (4 bit): indexes data bits 0..7 in DATA; cleared on entry to DATA.
- Sample strobe: asserted when baud_cnt==BAUD_MID.
- States:
  - IDLE: on falling edge go to START, busy=1, baud_cnt=0.
  - START: at the strobe, if rx_r2=1 the start bit was a glitch; return to IDLE with no outputs. If rx_r2=0, go to DATA.
  - DATA: at each strobe, shift rx_r2 into an internal shift register at the MSB, shifting right (LSB first on the wire). After bit_cnt=7 is sampled, go to STOP.
  - STOP: at the strobe, if rx_r2=1, load rx_data from the shift register and pulse rx_flag on the next cycle, then go to IDLE. If rx_r2=0, pulse frame_err, leave rx_data unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_r2=1, then go to IDLE. This prevents a break condition from re-triggering the receiver.
- Latency: rx_flag rises exactly 1 sclk after the stop-bit strobe. That is about 9.5 bit times plus 3 synchroniser cycles after the start edge on the pin.
- Back-to-back frames: returning to IDLE at mid-stop lets the receiver detect the next start edge with no dead bit time.
- rx_flag and frame_err are never high in the same cycle. Each pulse is exactly 1 cycle wide.
- Reset asserted mid-frame: all state returns to reset values on the next edge. The partial frame is discarded. A line that is still low after reset is not treated as a start bit until a new 1->0 edge occurs.
- busy=0 only in IDLE.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame becomes 8E1.
  - PARITY state is inserted between DATA and STOP and samples one extra bit.
  - Extra output parity_err (1 bit), reset to 0, pulses together with rx_flag when the XOR of the 8 data bits and the parity bit is 1.
  - rx_data still updates on a parity error, so consumers decide what to do with the byte.
  - Latency grows by exactly BAUD_END cycles.
- Undefined:
  - No PARITY state and no parity_err port.
  - 8N1 behaviour exactly as above.

Test Plan:
1. Set BAUD_END=16. Release reset with the line high, then send 8N1 byte 8'hA5 -> one rx_flag pulse, rx_data=8'hA5, frame_err never high, busy low afterwards.
2. Send bytes 8'h00, 8'hFF, 8'h55 back-to-back with 1-bit stop -> three rx_flag pulses, rx_data values in order, no byte lost.
3. Drive the line low for 4 cycles (less than BAUD_MID), then high -> no rx_flag, no frame_err, back in IDLE within BAUD_MID+4 cycles.
4. Send 8'h3C with the stop bit driven 0, then hold the line low for 40 cycles -> one frame_err pulse, rx_data keeps its previous value, no re-trigger until the line goes high, then the next byte 8'h81 is received correctly.
5. Assert s_rst during data bit 4 of 8'hC3 -> outputs at reset values on the next cycle, no rx_flag for the partial frame, next full byte 8'h7E received correctly.
6. With UART_RX_PARITY_EN defined, send 8'h07 with parity 1, then with parity 0 -> first frame parity_err=0; second frame parity_err pulses with rx_flag; rx_data=8'h07 both times.
